logic_proc_sequencer: RTL and testbench

Command-driven controller for the bit-serial logic processor: A/B 8-bit shift registers, a computation unit selected by F, and a routing unit selected by R. It buffers commands in a small FIFO and issues them to the datapath in order. LOADA and LOADB commands become one-cycle register loads. EXEC commands become exactly DATA_WIDTH shift cycles with F and R held stable. It replaces manual Execute/LoadA/LoadB toggling, so software or a bench can queue whole operation sequences.

---
 rtl/logic_proc_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_logic_proc_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_proc_sequencer.sv
// logic_proc_sequencer: command FIFO plus sequencing FSM for the bit-serial
// logic processor. Commands are queued in order and turned into one-cycle
// register loads (LOADA/LOADB), DATA_WIDTH shift cycles (EXEC), or a bare
// retire (NOP). Datapath outputs are decoded only from the state register and
// the latched current command, so cmd_* never reaches F/R/Din/Ld_*/Shift_En
// combinationally.
//
// Handshake: a command transfers at a rising edge where cmd_valid && cmd_ready
// are both high. cmd_ready depends only on the registered FIFO count (and
// Reset), never on cmd_valid. A transferred command is stored in the FIFO and
// is first visible to the FSM in the cycle after the transfer edge.
module logic_proc_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [2:0]            cmd_f,
  input  logic [1:0]            cmd_r,
  input  logic [DATA_WIDTH-1:0] cmd_din,
  output logic [2:0]            F,
  output logic [1:0]            R,
  output logic [DATA_WIDTH-1:0] Din,
  output logic                  Ld_A,
  output logic                  Ld_B,
  output logic                  Shift_En,
  output logic                  done,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW  = AW + 1;
  localparam int SHW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] OP_EXEC  = 2'b00;
  localparam logic [1:0] OP_LOADA = 2'b01;
  localparam logic [1:0] OP_LOADB = 2'b10;

  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);
  localparam logic [SHW-1:0]  LAST_SHIFT = SHW'(DATA_WIDTH - 1);

  typedef struct packed {
    logic [1:0]            op;
    logic [2:0]            f;
    logic [1:0]            r;
    logic [DATA_WIDTH-1:0] din;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state, state_n;
  cmd_t            mem [FIFO_DEPTH];
  cmd_t            head;
  cmd_t            cur;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic [SHW-1:0]  shift_cnt;
  logic            full;
  logic            push;
  logic            pop;

  // FIFO status and transfer qualifiers. Full blocks a push even when the
  // FSM pops in the same cycle: there is no full-FIFO bypass.
  always_comb begin
    full = (count == FULL_COUNT);
    push = cmd_valid && !full && !Reset;
    head = mem[rd_ptr];
  end

  // FIFO storage: written on accepted commands only, no reset needed.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, f: cmd_f, r: cmd_r, din: cmd_din};
    end
  end

  // FIFO pointers and occupancy count; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; IDLE pops the FIFO head whenever one is waiting.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          case (head.op)
            OP_EXEC:  state_n = S_SHIFT;
            OP_LOADA: state_n = S_LOAD;
            OP_LOADB: state_n = S_LOAD;
            default:  state_n = S_DONE;
          endcase
        end
      end
      S_LOAD:  state_n = S_DONE;
      S_SHIFT: if (shift_cnt == LAST_SHIFT) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Current-command registers, captured at the pop edge and held stable
  // for the whole operation regardless of later enqueues.
  always_ff @(posedge Clk) begin
    if (Reset)    cur <= '0;
    else if (pop) cur <= head;
  end

  // Shift counter: runs 0..DATA_WIDTH-1 in SHIFT and is zero elsewhere.
  always_ff @(posedge Clk) begin
    if (Reset || state != S_SHIFT) shift_cnt <= '0;
    else if (shift_cnt == LAST_SHIFT) shift_cnt <= '0;
    else shift_cnt <= shift_cnt + SHW'(1);
  end

  // Output decode from state and latched command; everything reads zero
  // while Reset is held.
  always_comb begin
    F         = '0;
    R         = '0;
    Din       = '0;
    Ld_A      = 1'b0;
    Ld_B      = 1'b0;
    Shift_En  = 1'b0;
    done      = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    if (!Reset) begin
      cmd_ready = !full;
      busy      = (state != S_IDLE) || (count != '0);
      case (state)
        S_LOAD: begin
          Din  = cur.din;
          Ld_A = (cur.op == OP_LOADA);
          Ld_B = (cur.op == OP_LOADB);
        end
        S_SHIFT: begin
          Shift_En = 1'b1;
          F        = cur.f;
          R        = cur.r;
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_logic_proc_sequencer.sv
// Bench for logic_proc_sequencer: directed sequences plus random command
// streams, with a behavioural model that expands each accepted command into
// the list of datapath events it must produce, checked in order by a monitor.
module tb_logic_proc_sequencer;

  localparam int DW = 8;
  localparam int EW = 4 + 3 + 2 + DW;

  logic          Clk;
  logic          Reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [2:0]    cmd_f;
  logic [1:0]    cmd_r;
  logic [DW-1:0] cmd_din;
  logic [2:0]    F;
  logic [1:0]    R;
  logic [DW-1:0] Din;
  logic          Ld_A, Ld_B, Shift_En, done, busy;
  logic [1:0]    state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int shift_run = 0;

  logic_proc_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_f(cmd_f), .cmd_r(cmd_r), .cmd_din(cmd_din),
    .F(F), .R(R), .Din(Din), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
    .done(done), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Event word: {Ld_A, Ld_B, Shift_En, done, F, R, Din}.
  function automatic logic [EW-1:0] ev(input logic la, input logic lb,
                                       input logic se, input logic dn,
                                       input logic [2:0] f, input logic [1:0] r,
                                       input logic [DW-1:0] d);
    return {la, lb, se, dn, f, r, d};
  endfunction

  // Reference model: what an accepted command must look like on the datapath.
  task automatic model_push(input logic [1:0] op, input logic [2:0] f,
                            input logic [1:0] r, input logic [DW-1:0] d);
    case (op)
      2'b00: for (int i = 0; i < DW; i++) exp_q.push_back(ev(0, 0, 1, 0, f, r, '0));
      2'b01: exp_q.push_back(ev(1, 0, 0, 0, '0, '0, d));
      2'b10: exp_q.push_back(ev(0, 1, 0, 0, '0, '0, d));
      default: ;
    endcase
    exp_q.push_back(ev(0, 0, 0, 1, '0, '0, '0));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic send(input logic [1:0] op, input logic [2:0] f, input logic [1:0] r,
                      input logic [DW-1:0] d, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_f = f; cmd_r = r; cmd_din = d;
    while (!ok && waited < 200) begin
      @(negedge Clk);
      if (cmd_ready) begin
        model_push(op, f, r, d);
        ok = 1;
      end else begin
        waited++;
      end
      @(posedge Clk); #1;
    end
    cmd_valid = 1'b0;
    cmd_op = $urandom_range(0, 3); cmd_din = $urandom_range(0, 255);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge Clk); #1;
      n++;
    end
    check("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_shift();
    int n;
    n = 0;
    @(negedge Clk);
    while (!Shift_En && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("shift_seen", {31'd0, Shift_En}, 32'd1);
    @(posedge Clk); #1;
  endtask

  // Single command from an empty FIFO: busy must stay high for exactly len cycles.
  task automatic timed_cmd(input string name, input logic [1:0] op, input logic [2:0] f,
                           input logic [1:0] r, input logic [DW-1:0] d, input int len);
    int w, n;
    wait_drained();
    send(op, f, r, d, w);
    n = 0;
    @(negedge Clk);
    while (busy && n < 100) begin
      n++;
      @(negedge Clk);
    end
    check(name, n, len);
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    exp_q.delete();
    idle_cycles(2);
    Reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Compares every active datapath cycle with the head of the expected queue.
  always @(negedge Clk) begin
    logic [EW-1:0] obs, e;
    if (Reset) begin
      check("reset_outputs", {F, R, Din, Ld_A, Ld_B, Shift_En, done, busy, cmd_ready}, 32'd0);
      shift_run = 0;
    end else begin
      obs = {Ld_A, Ld_B, Shift_En, done, F, R, Din};
      check("mutex", {31'd0, (Ld_A + Ld_B + Shift_En) <= 2'd1}, 32'd1);
      if (Ld_A || Ld_B || Shift_En || done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event actual=%0h required=none t=%0t", obs, $time);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL event actual=%0h required=%0h t=%0t", obs, e, $time);
          end
        end
      end else begin
        check("idle_outputs", {F, R, Din}, 32'd0);
      end
      if (Shift_En) shift_run++;
      else if (shift_run != 0) begin
        check("shift_run_len", shift_run, DW);
        shift_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    Reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_f = '0; cmd_r = '0; cmd_din = '0;
    idle_cycles(3);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    @(posedge Clk); #1;

    // Back-to-back loads and an EXEC: no back-pressure expected.
    send(2'b01, 3'b000, 2'b00, 8'h33, w); check("b2b_ready0", w, 0);
    send(2'b10, 3'b000, 2'b00, 8'h55, w); check("b2b_ready1", w, 0);
    send(2'b00, 3'b010, 2'b10, 8'h00, w); check("b2b_ready2", w, 0);
    wait_drained();

    // Isolated command latencies from pop cycle to return to IDLE.
    timed_cmd("exec_len", 2'b00, 3'b110, 2'b01, 8'h00, DW + 2);
    timed_cmd("exec_len2", 2'b00, 3'b110, 2'b11, 8'h00, DW + 2);
    timed_cmd("loada_len", 2'b01, 3'b000, 2'b00, 8'h5A, 3);
    timed_cmd("loadb_len", 2'b10, 3'b000, 2'b00, 8'hC3, 3);
    timed_cmd("nop_len", 2'b11, 3'b000, 2'b00, 8'h00, 2);

    // Fill the FIFO while an EXEC is shifting.
    wait_drained();
    send(2'b00, 3'b101, 2'b01, 8'h00, w);
    wait_shift();
    for (int i = 0; i < 4; i++) begin
      send(2'(i % 3), 3'(i + 1), 2'(i), 8'(8'h10 + i), w);
      check("fill_accept", w, 0);
    end
    cmd_valid = 1'b1;
    @(negedge Clk);
    check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(posedge Clk); #1;
    send(2'b01, 3'b000, 2'b00, 8'h99, w);
    check("fifth_accepted_late", {31'd0, w > 0}, 32'd1);
    wait_drained();

    // Reset during shift cycle 3 with two commands queued.
    send(2'b00, 3'b011, 2'b10, 8'h00, w);
    send(2'b01, 3'b000, 2'b00, 8'h11, w);
    send(2'b10, 3'b000, 2'b00, 8'h22, w);
    wait_shift();
    idle_cycles(1);
    do_reset();
    @(negedge Clk);
    check("after_reset_busy", {31'd0, busy}, 32'd0);
    check("after_reset_shift", {31'd0, Shift_En}, 32'd0);
    @(posedge Clk); #1;
    timed_cmd("loada_after_reset", 2'b01, 3'b000, 2'b00, 8'hA5, 3);

    // NOP then LOADB.
    send(2'b11, 3'b000, 2'b00, 8'h00, w);
    send(2'b10, 3'b000, 2'b00, 8'h0F, w);
    wait_drained();

    // Random command stream with random gaps.
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), w);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 6));
    end
    wait_drained();
    idle_cycles(2);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
